// File: rtl/enc_param_ctrl.sv
// Encoder-driven parameter controller: accumulates encoder steps into the selected
// parameter register, cycles the selection on button edges, and pushes each change to a display.
module enc_param_ctrl #(
    parameter int NUM_PARAMS = 4,
    parameter int VAL_W      = 8,
    parameter int WRAP       = 0,
    localparam int IDX_W     = $clog2(NUM_PARAMS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        add,
    input  logic                        sub,
    input  logic                        btn,
    output logic                        upd_valid,
    input  logic                        upd_ready,
    output logic [IDX_W-1:0]            upd_idx,
    output logic [VAL_W-1:0]            upd_val,
    output logic [IDX_W-1:0]            sel_idx,
    output logic [NUM_PARAMS*VAL_W-1:0] vals
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SELECT = 2'd2,
        SEND   = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   do_apply, do_select;

    logic signed [1:0] step;
    logic signed [3:0] pend, pend_base, pend_nxt;
    logic signed [4:0] pend_sum;

    logic btn_q, btn_edge, btn_pend;

    logic [NUM_PARAMS-1:0][VAL_W-1:0] val_r;
    logic [VAL_W-1:0]                 cur_val, new_val;
    logic signed [VAL_W+1:0]          val_sum;
    logic [IDX_W-1:0]                 sel_inc;

    // Net step this cycle; simultaneous add and sub cancel.
    always_comb begin
        step = 2'sd0;
        if (add && !sub)
            step = 2'sd1;
        else if (sub && !add)
            step = -2'sd1;
    end

    // In APPLY the old count is consumed, so only this cycle's step survives.
    always_comb begin
        pend_base = (state == APPLY) ? 4'sd0 : pend;
        pend_sum  = {pend_base[3], pend_base} + {{3{step[1]}}, step};
        pend_nxt  = pend_sum[3:0];
        if (pend_sum > 5'sd7)
            pend_nxt = 4'sd7;
        else if (pend_sum < -5'sd7)
            pend_nxt = -4'sd7;
    end

    assign btn_edge = btn & ~btn_q;

    always_comb begin
        cur_val = val_r[sel_idx];
        val_sum = $signed({2'b00, cur_val}) + $signed({{(VAL_W-2){pend[3]}}, pend});
        if (WRAP != 0)
            new_val = val_sum[VAL_W-1:0];
        else if (val_sum[VAL_W+1])
            new_val = '0;
        else if (val_sum[VAL_W])
            new_val = '1;
        else
            new_val = val_sum[VAL_W-1:0];
    end

    assign sel_inc = (sel_idx == IDX_W'(NUM_PARAMS - 1)) ? '0 : sel_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // IDLE looks at the count including this cycle's step, giving the two-cycle response.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pend_nxt != 4'sd0)
                    state_nxt = APPLY;
                else if (btn_pend)
                    state_nxt = SELECT;
            end
            APPLY:   state_nxt = SEND;
            SELECT:  state_nxt = SEND;
            SEND:    if (upd_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        upd_valid = (state == SEND);
        do_apply  = (state == APPLY);
        do_select = (state == SELECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= 4'sd0;
            btn_q    <= 1'b1;
            btn_pend <= 1'b0;
            sel_idx  <= '0;
            val_r    <= '0;
            upd_idx  <= '0;
            upd_val  <= '0;
        end else begin
            pend     <= pend_nxt;
            btn_q    <= btn;
            // An edge landing in the SELECT cycle is a fresh request, not the one being served.
            btn_pend <= btn_edge | (btn_pend & ~do_select);
            if (do_apply) begin
                val_r[sel_idx] <= new_val;
                upd_idx        <= sel_idx;
                upd_val        <= new_val;
            end
            if (do_select) begin
                sel_idx <= sel_inc;
                upd_idx <= sel_inc;
                upd_val <= val_r[sel_inc];
            end
        end
    end

    assign vals = val_r;

endmodule

// File: doc/enc_param_ctrl.md
ENC_PARAM_CTRL -- requirements
Module: enc_param_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_PARAMS, default 4, the number of independent adjustable parameter registers, range 2..16.
REQ-002 The block SHALL have parameter VAL_W, default 8, the width of each parameter register.
REQ-003 The block SHALL have parameter WRAP, default 0: 0 = saturate at 0 and 2^VAL_W-1; 1 = wrap modulo 2^VAL_W.
REQ-004 Port: clk  in  1  system clock, all logic on its rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-high.
REQ-006 Port: add  in  1  one-cycle increment pulse from the quadrature encoder decoder.
REQ-007 Port: sub  in  1  one-cycle decrement pulse from the quadrature encoder decoder.
REQ-008 Port: btn  in  1  debounced push-button level; a 0->1 edge selects the next parameter.
REQ-009 Port: upd_valid  out  1  display-update request, held until accepted.
REQ-010 Port: upd_ready  in  1  display controller accepts the update when upd_valid && upd_ready.
REQ-011 Port: upd_idx  out  clog2(NUM_PARAMS)  parameter index carried by the update.
REQ-012 Port: upd_val  out  VAL_W  parameter value carried by the update.
REQ-013 Port: sel_idx  out  clog2(NUM_PARAMS)  currently selected parameter.
REQ-014 Port: vals  out  NUM_PARAMS*VAL_W  all parameter registers, flattened, index 0 in the LSBs.

Function
REQ-015 The block SHALL run an FSM with states IDLE, APPLY, SELECT and SEND.
REQ-016 The block SHALL keep a signed pending-step counter pend, range -7..+7, updated every cycle in every state except reset.
REQ-017 pend SHALL increment on add only, decrement on sub only, and stay unchanged when add and sub are both high in the same cycle.
REQ-018 pend SHALL saturate at +7 and -7; further pulses in the same direction are dropped.
REQ-019 The block SHALL register btn and set a btn_pend flag on a 0->1 edge; repeated edges before service SHALL collapse into one selection.
REQ-020 IDLE: if pend != 0, go to APPLY; else if btn_pend, go to SELECT; else stay in IDLE.
REQ-021 APPLY (one cycle): vals[sel_idx] += pend with saturation or wrap per WRAP, using the pend value sampled on entry.
REQ-022 APPLY: steps arriving in the APPLY cycle SHALL be retained in pend and not lost.
REQ-023 APPLY: load upd_idx = sel_idx and upd_val = new value, then go to SEND.
REQ-024 SELECT (one cycle): sel_idx = (sel_idx+1) mod NUM_PARAMS, clear btn_pend, load upd_idx/upd_val with the new index and its value, then go to SEND.
REQ-025 SEND: hold upd_valid=1 with stable upd_idx/upd_val until upd_ready=1, then drop upd_valid and return to IDLE on the next cycle.
REQ-026 Encoder steps and button edges SHALL accumulate during SEND and be serviced afterwards; pending steps SHALL have priority over a pending selection.
REQ-027 Latency from an add pulse in IDLE to upd_valid=1 SHALL be exactly 2 cycles: pend updates at edge 1, APPLY at edge 2, upd_valid visible after edge 2.
REQ-028 upd_valid SHALL never be asserted in IDLE, APPLY or SELECT.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL force: state=IDLE, pend=0, btn_pend=0, sel_idx=0, all vals=0, upd_valid=0, upd_idx=0, upd_val=0, registered btn=1 (no spurious edge if the button is held).
REQ-030 Reset asserted in any state, including mid-SEND, SHALL abort the transfer immediately; no update is issued after reset.

Verification
REQ-031 Reset, 3 add pulses 1 cycle apart, upd_ready tied high -> vals[0] ends at 3, every update has upd_idx=0, last upd_val=3.
REQ-032 WRAP=0, vals[0]=0, 2 sub pulses -> vals[0] stays 0 and an update with upd_val=0 is still issued; WRAP=1 same stimulus -> vals[0]=254.
REQ-033 upd_ready held low 20 cycles while 10 add pulses arrive, then released -> exactly one APPLY follows, vals[0] increases by 7 (saturated pend), no further change.
REQ-034 Button edge, then add -> sel_idx=1, update (idx=1, val=0), then update (idx=1, val=1); vals[0] unchanged; 4 edges from sel_idx=0 -> sel_idx returns to 0.
REQ-035 add and sub high in the same cycle -> pend unchanged, no update issued.
REQ-036 rst asserted during SEND with vals[0]=5 -> next cycle upd_valid=0, vals all 0, sel_idx=0.
